csa_acc: RTL and testbench
==========================

# csa_acc

Sequential carry-save accumulator for the modular-multiplication datapath. It absorbs a stream of WIDTH-bit operands in redundant sum/carry form, one operand per cycle with no carry propagation. At the end of a group it resolves the redundant pair into a binary result with a multi-cycle, chunked carry-propagate add. It sits between partial-product generation and the reduction stage, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 256: operand width in bits.
- GUARD, 4: extra accumulator bits. Accumulator width W = WIDTH+GUARD.
- CHUNK, 65: bits resolved per RESOLVE cycle. NCH = ceil(W/CHUNK); the last chunk may be partial.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand valid.
- in_ready  out  1: accumulator accepts an operand.
- in_data  in  WIDTH: operand, zero-extended to W.
- in_last  in  1: marks the final operand of the group; qualified by the handshake.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- out_data  out  W: resolved sum, modulo 2^W.
- out_ovf  out  1: the group had more than 2^GUARD operands, so the result may have wrapped.

## Operation
- States: ACC, RESOLVE, OUT. Reset state is ACC.
- Registers: s[W-1:0], c[W-1:0], cnt[GUARD:0] (saturating), cin (1 bit), chunk index k, res[W-1:0].
- ACC
  - in_ready=1.
  - On handshake: s ← s^c^x and c ← (maj(s,c,x) << 1) truncated to W, where x = zero-extended in_data.
  - cnt ← sat(cnt+1).
  - If in_last: go to RESOLVE with k=0, cin=0.
- RESOLVE
  - in_ready=0.
  - Each cycle: {cout, res[chunk k]} ← s[chunk k] + c[chunk k] + cin; cin ← cout; k ← k+1.
  - After chunk NCH-1, go to OUT. Carry out of bit W-1 is discarded.
- OUT
  - out_valid=1; out_data=res and out_ovf=(cnt > 2^GUARD) are held stable.
  - On out_valid&&out_ready: s, c, cnt ← 0 and go to ACC.
- A group of exactly one operand (in_last on the first beat) yields that operand.
- The accumulated value is exact while cnt ≤ 2^GUARD. Beyond that it wraps modulo 2^W and out_ovf=1.
- in_data and in_last are ignored when no handshake occurs.
- rst at any time, including mid-RESOLVE or in OUT, aborts the group. No partial result is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0. s, c, cnt, res, k and cin are all 0.
- Throughput in ACC: one operand per cycle.
- Latency: if the in_last handshake is at edge E0, out_valid is high after edge E0+NCH+1 (RESOLVE takes NCH edges, entry into OUT takes one more). Default: NCH=4.
- out_valid stays high and out_data stays stable until the handshake. out_valid falls and in_ready rises at the handshake edge.
- in_ready=0 for the whole of RESOLVE and OUT. There is no overlap between groups.
- Critical path: one 3:2 compressor row in ACC; one CHUNK-bit adder plus the cin mux in RESOLVE.

## Structure
- Package csa_pkg contains:
  - state enum {ACC, RESOLVE, OUT};
  - function nch(W, CHUNK);
  - localparam helpers for W and for the index width clog2(NCH).
- Sub-module csa_row: purely combinational, parametrised on W. Outputs sum = a^b^d and carry = maj(a,b,d)<<1, truncated to W. csa_acc instantiates it once for the ACC update.
- Chunk selection uses an indexed part-select on k. The partial last chunk is masked to W.

## Test plan
Bench parameters: WIDTH=8, GUARD=4, CHUNK=4 (W=12, NCH=3) unless stated otherwise.
- Operands 0xFF, 0xFF, 0x01 (last) → out_data=0x1FF, out_ovf=0, out_valid high 4 cycles after the last handshake edge.
- Single operand 0xA5 with in_last → out_data=0x0A5. Operands 0x0F, 0x01 (last) → 0x010, checking the ripple across a chunk boundary.
- 16×0xFF → out_data=0xFF0, out_ovf=0. 17×0xFF → out_data=0x0EF (4335 mod 4096), out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles → out_data stable and in_ready=0 throughout. Handshake, then group 0x03 (last) → 0x003, proving the accumulator was cleared.
- Assert rst for 1 cycle during the second RESOLVE cycle → out_valid stays 0 and in_ready=1 after reset. Next group 0x05 (last) → 0x005, out_ovf=0.
- Defaults (WIDTH=256, NCH=4): 2^256−1 + 1 → out_data=2^256 (bit 256 set), result after 5 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_pkg;

  // Controller states: absorb operands, resolve the redundant pair, present result.
  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Default build: 256-bit operands, 4 guard bits, 65-bit resolve chunks.
  localparam int DEF_WIDTH = 256;
  localparam int DEF_GUARD = 4;
  localparam int DEF_CHUNK = 65;

  // Accumulator width: operand width plus guard bits.
  function automatic int acc_w(input int width, input int guard);
    return width + guard;
  endfunction

  // Number of chunks needed to cover w bits; the last one may be partial.
  function automatic int nch(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

  // Chunk index width. The index also has to hold the terminal count n,
  // which marks "all chunks resolved" for one extra cycle before OUT.
  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEF_W   = acc_w(DEF_WIDTH, DEF_GUARD);
  localparam int DEF_NCH = nch(DEF_W, DEF_CHUNK);
  localparam int DEF_KW  = idx_w(DEF_NCH);

endpackage

// File: rtl/csa_row.sv
// One 3:2 compressor row: folds three W-bit words into a sum/carry pair.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Carry weight is one bit higher; the bit shifted past W-1 is dropped (mod 2^W).
  assign sum   = a ^ b ^ d;
  assign carry = ((a & b) | (a & d) | (b & d)) << 1;

endmodule

// File: rtl/csa_acc.sv
// Carry-save accumulator: one operand per cycle in redundant form, then a
// chunked carry-propagate add resolves the group into a binary result.
module csa_acc
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+GUARD-1:0]   out_data,
  output logic                     out_ovf
);

  localparam int W   = acc_w(WIDTH, GUARD);
  localparam int NCH = nch(W, CHUNK);
  localparam int KW  = idx_w(NCH);
  localparam int WP  = NCH * CHUNK;  // width padded to whole chunks
  localparam logic [GUARD:0] CNT_LIM = {1'b1, {GUARD{1'b0}}};

  state_t           state, state_next;
  logic [W-1:0]     s, c, res, x;
  logic [W-1:0]     row_sum, row_carry, res_merge;
  logic [GUARD:0]   cnt;
  logic             cin;
  logic [KW-1:0]    k;
  logic [WP-1:0]    s_pad, c_pad;
  logic [CHUNK:0]   chunk_sum;
  int               sel;

  assign x = W'(in_data);

  csa_row #(.W(W)) u_row (
    .a    (s),
    .b    (c),
    .d    (x),
    .sum  (row_sum),
    .carry(row_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = RESOLVE;
      end
      RESOLVE: begin
        if (k == KW'(NCH)) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // Chunk adder: pick chunk k of s and c (zero-padded past W), add with carry-in,
  // then merge the result bits back into res; pad bits beyond W are never stored.
  always_comb begin
    sel       = (k < KW'(NCH)) ? int'(k) * CHUNK : 0;
    s_pad     = WP'(s);
    c_pad     = WP'(c);
    chunk_sum = {1'b0, s_pad[sel +: CHUNK]} + {1'b0, c_pad[sel +: CHUNK]}
              + {{CHUNK{1'b0}}, cin};
    res_merge = res;
    for (int i = 0; i < W; i++) begin
      if ((i / CHUNK) == int'(k)) res_merge[i] = chunk_sum[i % CHUNK];
    end
  end

  // Datapath registers: accumulate in ACC, ripple chunks in RESOLVE, clear on result accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= '0;
      c   <= '0;
      cnt <= '0;
      res <= '0;
      k   <= '0;
      cin <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            s <= row_sum;
            c <= row_carry;
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (in_last) begin
              k   <= '0;
              cin <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          if (k != KW'(NCH)) begin
            res <= res_merge;
            cin <= chunk_sum[CHUNK];
            k   <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            s   <= '0;
            c   <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = res;
  assign out_ovf  = (state == OUT) && (cnt > CNT_LIM);

endmodule

// File: tb/tb_csa_acc.sv
// Directed bench for csa_acc: small build (W=12, NCH=3) plus one default build.
module tb_csa_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Small instance: WIDTH=8, GUARD=4, CHUNK=4.
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data  = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_data;

  // Default instance: WIDTH=256, GUARD=4, CHUNK=65.
  logic         d_in_valid = 1'b0, d_in_last = 1'b0, d_out_ready = 1'b0;
  logic [255:0] d_in_data  = '0;
  logic         d_in_ready, d_out_valid, d_out_ovf;
  logic [259:0] d_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_acc #(.WIDTH(8), .GUARD(4), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  csa_acc dut_d (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_ovf(d_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for exactly one edge (DUT in ACC, so it handshakes).
  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h5A;
  endtask

  // Count edges from the last handshake until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic take(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic check_result(input string name, input logic [11:0] exp_data,
                              input logic exp_ovf, input int exp_lat);
    int n;
    wait_valid(n);
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, n, exp_lat);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++;
      $display("FAIL %s_data got %h want %h", name, out_data, exp_data);
    end
    checks++;
    if (out_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s_ovf got %b want %b", name, out_ovf, exp_ovf);
    end
    $display("txn %s data=%h ovf=%b latency=%0d", name, out_data, out_ovf, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_in got ready=%b valid=%b data=%h ovf=%b want 1 0 000 0",
               in_ready, out_valid, out_data, out_ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_after got ready=%b valid=%b data=%h ovf=%b want 1 0 000 0",
               in_ready, out_valid, out_data, out_ovf);
    end
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_out_data !== '0) begin
      errors++;
      $display("FAIL reset_default got ready=%b valid=%b want 1 0", d_in_ready, d_out_valid);
    end
    $display("txn reset done");
  endtask

  task automatic test_basic();
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    check_result("basic", 12'h1FF, 1'b0, 4);
    take("basic");
  endtask

  task automatic test_single_and_ripple();
    send(8'hA5, 1'b1);
    check_result("single", 12'h0A5, 1'b0, 4);
    take("single");
    send(8'h0F, 1'b0);
    send(8'h01, 1'b1);
    check_result("ripple", 12'h010, 1'b0, 4);
    take("ripple");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send(8'hFF, (i == 15));
    check_result("sixteen", 12'hFF0, 1'b0, 4);
    take("sixteen");
    for (int i = 0; i < 17; i++) send(8'hFF, (i == 16));
    check_result("seventeen", 12'h0EF, 1'b1, 4);
    take("seventeen");
  endtask

  task automatic test_backpressure();
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    check_result("bp", 12'h046, 1'b0, 4);
    // Offer a stray operand while stalled; it must be ignored.
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'h046 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b data=%h ready=%b want 1 046 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    take("bp");
    send(8'h03, 1'b1);
    check_result("after_bp", 12'h003, 1'b0, 4);
    take("after_bp");
  endtask

  task automatic test_reset_mid_resolve();
    send(8'h07, 1'b0);
    send(8'h09, 1'b1);
    tick();               // first RESOLVE edge done; now in the second RESOLVE cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet%0d got valid=%b want 0", i, out_valid);
      end
    end
    send(8'h05, 1'b1);
    check_result("after_rst", 12'h005, 1'b0, 4);
    take("after_rst");
  endtask

  task automatic test_defaults();
    int n;
    logic [259:0] exp;
    exp = '0;
    exp[256] = 1'b1;
    d_in_valid = 1'b1; d_in_data = '1; d_in_last = 1'b0;
    tick();
    d_in_data = 256'd1; d_in_last = 1'b1;
    tick();
    d_in_valid = 1'b0; d_in_last = 1'b0;
    n = 0;
    while (!d_out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL default_latency got %0d want 5", n);
    end
    checks++;
    if (d_out_data !== exp || d_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL default_data got %h ovf=%b want %h ovf=0", d_out_data, d_out_ovf, exp);
    end
    $display("txn default data=%h latency=%0d", d_out_data, n);
    d_out_ready = 1'b1;
    tick();
    d_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_and_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_resolve();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
